// File: rtl/accel_disp_pkg.sv
// Shared types and constants for the accelerometer display path.
package accel_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGITS          = 4;
  localparam int unsigned BCD_W               = 4 * BCD_DIGITS;
  localparam int unsigned BCD_MAX             = 9999;
  localparam int unsigned REFRESH_DIV_DEFAULT = 100000;

  // Double-dabble pre-shift correction: every nibble >= 5 gets +3.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/refresh_scan.sv
// Display refresh prescaler and 2-bit digit-select scan index.
module refresh_scan
  import accel_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] array
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0] prescaler;

  // Index advances on the prescaler wrap, so each value holds REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      array     <= 2'd0;
    end else if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
      prescaler <= '0;
      array     <= array + 2'd1;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// Sample-to-BCD converter (sequential double-dabble) plus display scan index.
// Optional `ACCEL_SIGNED_EN: two's complement samples, magnitude shown, sign on neg.
module bcd_scan_driver
  import accel_disp_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [3:0]        thousands,
  output logic [3:0]        hundreds,
  output logic [3:0]        tens,
  output logic [3:0]        ones,
  output logic              digits_valid,
  output logic              neg,
  output logic [1:0]        array
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  digits_d;
  logic              valid_d;
  logic              ready_d;
  logic              handshake;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] operand_ld;

  assign handshake = sample_valid && sample_ready;

`ifdef ACCEL_SIGNED_EN
  // Most negative value negates to itself, which reads correctly as unsigned.
  assign mag = sample[DATA_W-1] ? DATA_W'(-sample) : sample;
`else
  assign mag = sample;
`endif

  assign operand_ld = (32'(mag) > BCD_MAX) ? DATA_W'(BCD_MAX) : mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                            <= IDLE;
      operand_q                          <= '0;
      bcd_q                              <= '0;
      cnt_q                              <= '0;
      {thousands, hundreds, tens, ones}  <= '0;
      digits_valid                       <= 1'b0;
      sample_ready                       <= 1'b1;
    end else begin
      state_q                            <= state_d;
      operand_q                          <= operand_d;
      bcd_q                              <= bcd_d;
      cnt_q                              <= cnt_d;
      {thousands, hundreds, tens, ones}  <= digits_d;
      digits_valid                       <= valid_d;
      sample_ready                       <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    digits_d  = {thousands, hundreds, tens, ones};
    valid_d   = 1'b0;
    ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          operand_d = operand_ld;
          bcd_d     = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Adjust then shift {bcd, operand} left by one.
        bcd_d     = BCD_W'({bcd_adjust(bcd_q), operand_q[DATA_W-1]});
        operand_d = operand_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        digits_d = bcd_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

`ifdef ACCEL_SIGNED_EN
  logic neg_pend;

  // Sign captured at the handshake, published with the digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_pend <= 1'b0;
      neg      <= 1'b0;
    end else begin
      if (state_q == IDLE && handshake) neg_pend <= sample[DATA_W-1];
      if (state_q == DONE)              neg      <= neg_pend;
    end
  end
`else
  assign neg = 1'b0;
`endif

  refresh_scan #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh_scan (
    .clk  (clk),
    .rst  (rst),
    .array(array)
  );

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver (12-bit and 14-bit instances, REFRESH_DIV=4).
module tb_bcd_scan_driver;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        digits_valid;
  logic        neg;
  logic [1:0]  array;

  logic [13:0] sample2;
  logic        sample2_valid;
  logic        sample2_ready;
  logic [3:0]  thousands2, hundreds2, tens2, ones2;
  logic        digits2_valid;
  logic        neg2;
  logic [1:0]  array2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit scan_on = 1'b0;

`ifdef ACCEL_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  bcd_scan_driver #(.DATA_W(12), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .digits_valid(digits_valid), .neg(neg), .array(array)
  );

  bcd_scan_driver #(.DATA_W(14), .REFRESH_DIV(4)) dut14 (
    .clk(clk), .rst(rst), .sample(sample2), .sample_valid(sample2_valid),
    .sample_ready(sample2_ready), .thousands(thousands2), .hundreds(hundreds2),
    .tens(tens2), .ones(ones2), .digits_valid(digits2_valid), .neg(neg2), .array(array2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge. Scan index model: (edges since reset release / 4) mod 4.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (scan_on) chk("array", 32'(array), 32'((cyc / 4) % 4));
  endtask

  function automatic logic [15:0] digs();
    return {thousands, hundreds, tens, ones};
  endfunction

  task automatic convert(input string tag, input logic [11:0] val,
                         input logic [15:0] exp_d, input logic exp_neg);
    logic [15:0] prev;
    prev         = digs();
    sample       = val;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) tick();
      chk({tag, "_busy_ready"}, 32'(sample_ready), 32'd0);
      chk({tag, "_busy_dv"}, 32'(digits_valid), 32'd0);
      chk({tag, "_busy_digits"}, 32'(digs()), 32'(prev));
    end
    tick();
    chk({tag, "_digits"}, 32'(digs()), 32'(exp_d));
    chk({tag, "_dv"}, 32'(digits_valid), 32'd1);
    chk({tag, "_ready"}, 32'(sample_ready), 32'd1);
    chk({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    tick();
    chk({tag, "_dv_drop"}, 32'(digits_valid), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    sample        = '0;
    sample_valid  = 1'b0;
    sample2       = '0;
    sample2_valid = 1'b0;

    repeat (3) tick();
    chk("rst_digits", 32'(digs()), 32'h0);
    chk("rst_array", 32'(array), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_dv", 32'(digits_valid), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_ready14", 32'(sample2_ready), 32'd1);
    chk("rst_array14", 32'(array2), 32'd0);

    rst     = 1'b0;
    cyc     = 0;
    scan_on = 1'b1;

    convert("d1234", 12'd1234, 16'h1234, 1'b0);
    if (SIGNED_MODE) convert("hfff", 12'hFFF, 16'h0001, 1'b1);
    else             convert("hfff", 12'hFFF, 16'h4095, 1'b0);
    convert("h800", 12'h800, 16'h2048, SIGNED_MODE);

    // Valid held high; sample changes mid-conversion and is taken only at next IDLE.
    sample       = 12'd42;
    sample_valid = 1'b1;
    tick();
    sample = 12'd777;
    chk("hold_ready0", 32'(sample_ready), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("hold_busy_digits", 32'(digs()), 32'h2048);
    end
    tick();
    chk("hold_first", 32'(digs()), 32'h0042);
    chk("hold_first_dv", 32'(digits_valid), 32'd1);
    chk("hold_first_ready", 32'(sample_ready), 32'd1);
    tick();
    chk("hold_accept_ready", 32'(sample_ready), 32'd0);
    chk("hold_accept_dv", 32'(digits_valid), 32'd0);
    chk("hold_accept_digits", 32'(digs()), 32'h0042);
    sample_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("hold2_busy_ready", 32'(sample_ready), 32'd0);
    end
    tick();
    chk("hold_second", 32'(digs()), 32'h0777);
    chk("hold_second_dv", 32'(digits_valid), 32'd1);
    tick();

    // Reset five cycles into a conversion, with a handshake attempt on the reset edge.
    sample       = 12'd999;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (5) tick();
    scan_on      = 1'b0;
    rst          = 1'b1;
    sample_valid = 1'b1;
    tick();
    chk("abort_digits", 32'(digs()), 32'h0);
    chk("abort_ready", 32'(sample_ready), 32'd1);
    chk("abort_dv", 32'(digits_valid), 32'd0);
    chk("abort_array", 32'(array), 32'd0);
    rst          = 1'b0;
    sample_valid = 1'b0;
    cyc          = 0;
    scan_on      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("abort_no_dv", 32'(digits_valid), 32'd0);
      chk("abort_idle_ready", 32'(sample_ready), 32'd1);
      chk("abort_hold_digits", 32'(digs()), 32'h0);
    end

    // 14-bit instance: 12000 clamps unsigned; signed it is -4384.
    sample2       = 14'd12000;
    sample2_valid = 1'b1;
    tick();
    sample2_valid = 1'b0;
    chk("w14_ready0", 32'(sample2_ready), 32'd0);
    repeat (14) tick();
    chk("w14_busy_ready", 32'(sample2_ready), 32'd0);
    chk("w14_busy_dv", 32'(digits2_valid), 32'd0);
    tick();
    chk("w14_digits", 32'({thousands2, hundreds2, tens2, ones2}),
        SIGNED_MODE ? 32'h4384 : 32'h9999);
    chk("w14_neg", 32'(neg2), 32'(SIGNED_MODE));
    chk("w14_dv", 32'(digits2_valid), 32'd1);
    chk("w14_ready", 32'(sample2_ready), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
